// File: rtl/block_interleaver_buffer.sv
// block_interleaver_buffer: ping-pong row/column block interleaver on AXI4-Stream.
// One bank fills in arrival order while the other drains in permuted order;
// the permutation (interleave or de-interleave) is chosen per block.
module block_interleaver_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [1:0]            bank_full,
    output logic [CNT_WIDTH-1:0]  block_count,
    output logic                  err_tlast
);

    localparam int N       = ROWS * COLS;
    localparam int IDX_W   = $clog2(N);
    localparam int MAX_DIM = (ROWS > COLS) ? ROWS : COLS;
    localparam int CTR_W   = $clog2(MAX_DIM);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [CTR_W-1:0] ROWS_M1   = CTR_W'(ROWS - 1);
    localparam logic [CTR_W-1:0] COLS_M1   = CTR_W'(COLS - 1);
    localparam logic [IDX_W-1:0] ROWS_STEP = IDX_W'(ROWS);
    localparam logic [IDX_W-1:0] COLS_STEP = IDX_W'(COLS);

    typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [2][N];

    // Write side state
    logic             ready_en;
    logic             wr_ptr;
    logic [IDX_W-1:0] wr_k;
    logic [1:0]       bank_mode;
    logic             s_fire;
    logic             wr_last;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;

    // Read address generation: inner counter runs fastest, outer counts wraps
    rd_state_t        state, state_d;
    logic             rd_ptr;
    logic             rd_mode;
    logic [CTR_W-1:0] in_cnt;
    logic [CTR_W-1:0] out_cnt;
    logic [IDX_W-1:0] rd_addr;
    logic             issued_all;
    logic             in_wrap, out_wrap, issue_last;
    logic             issue;
    logic             next_full;

    // Read data register (skid) and output register
    logic                  q_vld, q_last;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  out_valid, out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_load, q_free, out_fire, last_fire;

    assign s_axis_tready = ready_en & ~bank_full[wr_ptr];
    assign s_fire        = s_axis_tvalid & s_axis_tready;
    assign wr_last       = (wr_k == LAST_IDX);
    assign full_set      = {wr_ptr, ~wr_ptr} & {2{s_fire & wr_last}};
    assign full_clr      = {rd_ptr, ~rd_ptr} & {2{last_fire}};
    assign next_full     = bank_full[~rd_ptr] | full_set[~rd_ptr];

    // Mode 0: inner = row (stride COLS). Mode 1: inner = column (stride ROWS).
    assign rd_mode    = bank_mode[rd_ptr];
    assign in_wrap    = rd_mode ? (in_cnt == COLS_M1) : (in_cnt == ROWS_M1);
    assign out_wrap   = rd_mode ? (out_cnt == ROWS_M1) : (out_cnt == COLS_M1);
    assign issue_last = in_wrap & out_wrap;

    assign out_load  = q_vld & (~out_valid | m_axis_tready);
    assign q_free    = ~q_vld | out_load;
    assign out_fire  = out_valid & m_axis_tready;
    assign last_fire = out_fire & out_last;

    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;

    // Write side: fill the current bank in arrival order, capture mode, check tlast.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en  <= 1'b0;
            wr_ptr    <= 1'b0;
            wr_k      <= '0;
            bank_mode <= '0;
            err_tlast <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            ready_en <= 1'b1;
            if (s_fire) begin
                if (wr_k == '0) bank_mode[wr_ptr] <= mode;
                if (s_axis_tlast != wr_last) err_tlast <= 1'b1;
                if (wr_last) begin
                    wr_k   <= '0;
                    wr_ptr <= ~wr_ptr;
                end else begin
                    wr_k <= wr_k + IDX_W'(1);
                end
            end
        end
    end

    // Sample storage with a registered read port.
    // NOTE: the memory has no reset; contents are don't-care until written and this keeps it RAM-inferable.
    always_ff @(posedge ACLK) begin
        if (s_fire) mem[wr_ptr][wr_k] <= s_axis_tdata;
        if (issue)  q_data <= mem[rd_ptr][rd_addr];
    end

    // Bank flags: fill and drain always target different banks, so both apply.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) bank_full <= 2'b00;
        else          bank_full <= (bank_full | full_set) & ~full_clr;
    end

    // Read address counters, read pointer and completed-block counter.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            in_cnt      <= '0;
            out_cnt     <= '0;
            rd_addr     <= '0;
            issued_all  <= 1'b0;
            rd_ptr      <= 1'b0;
            block_count <= '0;
        end else begin
            if (issue) begin
                if (issue_last) begin
                    in_cnt     <= '0;
                    out_cnt    <= '0;
                    rd_addr    <= '0;
                    issued_all <= 1'b1;
                end else if (in_wrap) begin
                    in_cnt  <= '0;
                    out_cnt <= out_cnt + CTR_W'(1);
                    rd_addr <= IDX_W'(out_cnt) + IDX_W'(1);
                end else begin
                    in_cnt  <= in_cnt + CTR_W'(1);
                    rd_addr <= rd_addr + (rd_mode ? ROWS_STEP : COLS_STEP);
                end
            end
            if (last_fire) begin
                issued_all  <= 1'b0;
                rd_ptr      <= ~rd_ptr;
                block_count <= block_count + CNT_WIDTH'(1);
            end
        end
    end

    // Skid stage: holds an issued read until the output register can take it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            q_vld  <= 1'b0;
            q_last <= 1'b0;
        end else if (issue) begin
            q_vld  <= 1'b1;
            q_last <= issue_last;
        end else if (out_load) begin
            q_vld <= 1'b0;
        end
    end

    // Output register: data and tlast stay put while stalled.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_last  <= q_last;
            out_data  <= q_data;
        end else if (m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= RD_IDLE;
        else          state <= state_d;
    end

    // Read FSM next state and read-issue decision.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state;
        issue   = 1'b0;
        unique case (state)
            RD_IDLE: begin
                if (bank_full[rd_ptr]) state_d = RD_PRIME;
            end
            RD_PRIME: begin
                issue   = 1'b1;
                state_d = RD_STREAM;
            end
            RD_STREAM: begin
                issue = ~issued_all & q_free;
                if (last_fire) state_d = next_full ? RD_PRIME : RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_interleaver_buffer.sv
// tb_block_interleaver_buffer: scoreboard bench for the ping-pong block interleaver.
// Expected output blocks are built from the row/column definition when a block is driven.
module tb_block_interleaver_buffer;

    localparam int DW     = 8;
    localparam int ROWS   = 4;
    localparam int COLS   = 8;
    localparam int N      = ROWS * COLS;
    localparam int CW     = 16;
    localparam int BUDGET = 500;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          tb_ACLK;
    logic          ARESETN;
    logic          mode;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [1:0]    bank_full;
    logic [CW-1:0] block_count;
    logic          err_tlast;

    int            tests_run    = 0;
    int            tests_failed = 0;
    exp_t          sb[$];
    logic [DW-1:0] blk [N];

    block_interleaver_buffer #(
        .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .CNT_WIDTH(CW)
    ) dut (
        .ACLK         (tb_ACLK),
        .ARESETN      (ARESETN),
        .mode         (mode),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .bank_full    (bank_full),
        .block_count  (block_count),
        .err_tlast    (err_tlast)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic fill_block(input int base, input bit rnd);
        for (int k = 0; k < N; k++) blk[k] = rnd ? DW'($urandom) : DW'(base + k);
    endtask

    // Reference permutation straight from the row/column definition.
    task automatic push_expected(input bit m);
        exp_t e;
        if (!m) begin
            for (int c = 0; c < COLS; c++)
                for (int r = 0; r < ROWS; r++) begin
                    e.data = blk[r*COLS + c];
                    e.last = (c == COLS-1) && (r == ROWS-1);
                    sb.push_back(e);
                end
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    e.data = blk[c*ROWS + r];
                    e.last = (r == ROWS-1) && (c == COLS-1);
                    sb.push_back(e);
                end
        end
    endtask

    // Drives blk[lo..hi]; returns one tick after the edge that accepts blk[hi].
    task automatic send_range(input int lo, input int hi, input bit m, input int tlast_at);
        int wait_cyc;
        for (int k = lo; k <= hi; k++) begin
            s_axis_tdata  = blk[k];
            s_axis_tlast  = (k == tlast_at);
            s_axis_tvalid = 1'b1;
            mode          = m;
            wait_cyc      = 0;
            @(negedge tb_ACLK);
            while (!s_axis_tready && wait_cyc < BUDGET) begin
                @(negedge tb_ACLK);
                wait_cyc++;
            end
            if (!s_axis_tready) begin
                tests_run++;
                tests_failed++;
                $display("FAIL send_timeout k=%0d: s_axis_tready=%b, required 1", k, s_axis_tready);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(posedge tb_ACLK);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Pops and compares each output handshake; checks hold-while-stalled.
    task automatic collect(input int count, input int ready_pct, input int budget, output int cycles);
        int            got;
        logic          stalled;
        logic [DW-1:0] held_data;
        logic          held_last;
        exp_t          e;
        got = 0; cycles = 0; stalled = 1'b0; held_data = '0; held_last = 1'b0;
        while (got < count && cycles < budget) begin
            @(posedge tb_ACLK);
            #1;
            m_axis_tready = ($urandom_range(99) < ready_pct);
            @(negedge tb_ACLK);
            cycles++;
            if (stalled) begin
                tests_run++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_data || m_axis_tlast !== held_last) begin
                    tests_failed++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_data, held_last);
                end
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_out: data=%h, required no output", m_axis_tdata);
                end else begin
                    e = sb.pop_front();
                    if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
                        tests_failed++;
                        $display("FAIL out_sample #%0d: data=%h last=%b, required data=%h last=%b",
                                 got, m_axis_tdata, m_axis_tlast, e.data, e.last);
                    end
                end
                got++;
                stalled = 1'b0;
            end else begin
                stalled   = (m_axis_tvalid === 1'b1);
                held_data = m_axis_tdata;
                held_last = m_axis_tlast;
            end
        end
        if (got < count) begin
            tests_run++;
            tests_failed++;
            $display("FAIL collect_timeout: got %0d samples, required %0d", got, count);
        end
    endtask

    task automatic expect_reset_outputs(input string tag);
        tests_run++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 ||
            m_axis_tlast !== 1'b0 || bank_full !== 2'b00 || block_count !== '0 || err_tlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: tready=%b tvalid=%b tdata=%h tlast=%b full=%b count=%0d err=%b, required all 0",
                     tag, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, bank_full, block_count, err_tlast);
        end
    endtask

    task automatic expect_drained(input string tag, input int blocks, input logic err);
        @(posedge tb_ACLK);
        #1;
        tests_run++;
        if (block_count !== CW'(blocks) || bank_full !== 2'b00 || err_tlast !== err ||
            m_axis_tvalid !== 1'b0 || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s: count=%0d full=%b err=%b tvalid=%b pending=%0d, required count=%0d full=00 err=%b tvalid=0 pending=0",
                     tag, block_count, bank_full, err_tlast, m_axis_tvalid, sb.size(), blocks, err);
        end
    endtask

    task automatic apply_reset;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        ARESETN       = 1'b0;
        repeat (2) @(posedge tb_ACLK);
        #1 ARESETN = 1'b1;
        @(posedge tb_ACLK);
        #1;
        sb.delete();
    endtask

    task automatic test_reset;
        s_axis_tvalid = 1'b1;
        ARESETN       = 1'b0;
        repeat (2) @(posedge tb_ACLK);
        #1;
        expect_reset_outputs("reset_values");
        ARESETN = 1'b1;
        #1;
        tests_run++;
        if (s_axis_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_before_edge: s_axis_tready=%b, required 0", s_axis_tready);
        end
        s_axis_tvalid = 1'b0;
        @(posedge tb_ACLK);
        #1;
        tests_run++;
        if (s_axis_tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_edge: s_axis_tready=%b, required 1", s_axis_tready);
        end
    endtask

    task automatic test_interleave;
        int lat, cyc;
        apply_reset();
        fill_block(0, 1'b0);
        push_expected(1'b0);
        send_range(0, N-1, 1'b0, N-1);
        lat = 0;
        while (m_axis_tvalid !== 1'b1 && lat < 10) begin
            @(posedge tb_ACLK);
            #1;
            lat++;
        end
        tests_run++;
        if (lat != 3) begin
            tests_failed++;
            $display("FAIL latency: %0d cycles, required 3", lat);
        end
        collect(N, 100, BUDGET, cyc);
        tests_run++;
        if (cyc != N) begin
            tests_failed++;
            $display("FAIL throughput: %0d cycles for %0d samples, required %0d", cyc, N, N);
        end
        expect_drained("interleave_end", 1, 1'b0);
    endtask

    task automatic test_deinterleave;
        int cyc;
        apply_reset();
        fill_block(0, 1'b0);
        push_expected(1'b1);
        fork
            send_range(0, N-1, 1'b1, N-1);
            collect(N, 100, BUDGET, cyc);
        join
        expect_drained("deinterleave_end", 1, 1'b0);
    endtask

    task automatic test_back_to_back;
        int cyc;
        apply_reset();
        fill_block(0, 1'b0);
        push_expected(1'b0);
        send_range(0, N-1, 1'b0, N-1);
        fill_block(100, 1'b0);
        push_expected(1'b1);
        send_range(0, N-1, 1'b1, N-1);
        tests_run++;
        if (s_axis_tready !== 1'b0 || bank_full !== 2'b11) begin
            tests_failed++;
            $display("FAIL both_full: tready=%b full=%b, required tready=0 full=11", s_axis_tready, bank_full);
        end
        fork
            begin
                fill_block(0, 1'b1);
                push_expected(1'b0);
                send_range(0, N-1, 1'b0, N-1);
            end
            collect(3*N, 100, 4*BUDGET, cyc);
        join
        expect_drained("back_to_back_end", 3, 1'b0);
    endtask

    task automatic test_random_tready;
        int cyc;
        apply_reset();
        fork
            begin
                fill_block(0, 1'b1);
                push_expected(1'b0);
                send_range(0, N-1, 1'b0, N-1);
                fill_block(0, 1'b1);
                push_expected(1'b1);
                send_range(0, N-1, 1'b1, N-1);
            end
            collect(2*N, 50, 6*BUDGET, cyc);
        join
        expect_drained("random_tready_end", 2, 1'b0);
    endtask

    task automatic test_tlast_error;
        int cyc;
        apply_reset();
        fill_block(50, 1'b0);
        push_expected(1'b0);
        send_range(0, 9, 1'b0, 10);
        tests_run++;
        if (err_tlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_early: err_tlast=%b, required 0", err_tlast);
        end
        send_range(10, 10, 1'b0, 10);
        tests_run++;
        if (err_tlast !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_set: err_tlast=%b, required 1", err_tlast);
        end
        send_range(11, N-1, 1'b0, 10);
        collect(N, 100, BUDGET, cyc);
        expect_drained("tlast_error_end", 1, 1'b1);
    endtask

    task automatic test_reset_mid_input;
        int cyc;
        apply_reset();
        fill_block(200, 1'b0);
        send_range(0, 16, 1'b0, N-1);
        s_axis_tdata  = blk[17];
        s_axis_tvalid = 1'b1;
        #2 ARESETN = 1'b0;
        #1;
        expect_reset_outputs("reset_mid_input");
        s_axis_tvalid = 1'b0;
        @(posedge tb_ACLK);
        #1 ARESETN = 1'b1;
        @(posedge tb_ACLK);
        #1;
        fill_block(0, 1'b1);
        push_expected(1'b0);
        fork
            send_range(0, N-1, 1'b0, N-1);
            collect(N, 100, BUDGET, cyc);
        join
        expect_drained("reset_mid_input_end", 1, 1'b0);
    endtask

    task automatic test_reset_mid_output;
        int cyc;
        apply_reset();
        fill_block(0, 1'b1);
        push_expected(1'b0);
        send_range(0, N-1, 1'b0, N-1);
        collect(5, 100, BUDGET, cyc);
        @(posedge tb_ACLK);
        #1;
        m_axis_tready = 1'b0;
        ARESETN       = 1'b0;
        #1;
        expect_reset_outputs("reset_mid_output");
        sb.delete();
        @(posedge tb_ACLK);
        #1 ARESETN = 1'b1;
        @(posedge tb_ACLK);
        #1;
        fill_block(0, 1'b1);
        push_expected(1'b0);
        fork
            send_range(0, N-1, 1'b0, N-1);
            collect(N, 100, BUDGET, cyc);
        join
        expect_drained("reset_mid_output_end", 1, 1'b0);
    endtask

    initial begin
        ARESETN       = 1'b0;
        mode          = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_interleave();
        test_deinterleave();
        test_back_to_back();
        test_random_tready();
        test_tlast_error();
        test_reset_mid_input();
        test_reset_mid_output();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/block_interleaver_buffer.md
# block_interleaver_buffer

Parametrised ping-pong block interleaver/de-interleaver placed on the AXI4-Stream data path between the encoder and modulator (interleave) or demodulator and decoder (de-interleave). It is the successor to the fixed interleaver data buffer:

- Rows, columns and sample width are generic.
- It double-buffers so that one block is filled while the previous one drains.
- Mode is selectable per block.
- Status is exported for the AXI-Lite register file.

## Interface
- DATA_WIDTH, 8, sample width in bits
- ROWS, 4, interleaver rows (≥2)
- COLS, 8, interleaver columns (≥2); block length N = ROWS*COLS
- CNT_WIDTH, 16, width of the completed-block counter
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- mode  in  1  0 = interleave, 1 = de-interleave; sampled when the first sample of a block is accepted
- s_axis_tdata  in  DATA_WIDTH  input sample
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end-of-block marker, checked only
- m_axis_tdata  out  DATA_WIDTH  output sample
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  high on the last sample of each output block
- bank_full  out  2  per-bank full flag
- block_count  out  CNT_WIDTH  blocks fully emitted, wraps modulo 2^CNT_WIDTH
- err_tlast  out  1  sticky; set on tlast mismatch; cleared only by reset

## Operation
- Memory: two banks (bank 0 and bank 1), each of N × DATA_WIDTH. A bank is EMPTY or FULL. A write pointer selects the bank being filled and a read pointer selects the bank being drained; both start at bank 0.
- Write side:
  - s_axis_tready = 1 when the write bank is EMPTY.
  - Each accepted sample is stored at linear index k = 0..N-1, in arrival order.
  - When k = N-1 is accepted, the write bank becomes FULL, the write pointer toggles and k resets to 0.
  - The mode sampled at k = 0 is stored with the bank.
- tlast check:
  - s_axis_tlast = 1 at k ≠ N-1 sets err_tlast.
  - s_axis_tlast = 0 at k = N-1 also sets err_tlast.
  - The block is still accepted as N samples; there is no resync.
- Read order, output index n = 0..N-1:
  - Interleave (mode 0): n = c*ROWS + r reads index r*COLS + c.
  - De-interleave (mode 1): n = r*COLS + c reads index c*ROWS + r.
  - The index is generated with row/column counters; there is no multiplier.
- Read FSM:
  - IDLE → PRIME when the read bank is FULL.
  - PRIME issues a registered memory read for n = 0, then → STREAM.
  - STREAM: each output handshake advances n and issues the next read.
  - On the handshake of n = N-1: the read bank becomes EMPTY, the read pointer toggles, block_count increments, and the FSM → PRIME if the other bank is FULL, otherwise → IDLE.
- Output register and backpressure:
  - The output register holds data and tlast stable while tvalid = 1 and tready = 0.
  - A one-entry skid holds the already-issued read, so no sample is lost or duplicated.
- Simultaneous events: if a bank goes FULL (write) on the same cycle the other bank goes EMPTY (read), both updates apply; neither flag update is lost.
- Reset: on ARESETN = 0, which may occur mid-block, the state is as follows.
  - Bank flags clear.
  - Both pointers go to bank 0; counters clear.
  - The FSM goes to IDLE.
  - Memory contents are don't-care.
  - Partial blocks are discarded.

## Timing
- Reset values:
  - s_axis_tready = 0 while ARESETN is low, and 1 from the first clock edge after release.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
  - bank_full = 2'b00, block_count = 0, err_tlast = 0.
- Latency: m_axis_tvalid rises exactly 3 cycles after the edge that accepts the last input sample of a block, provided the reader was IDLE.
- Throughput:
  - With m_axis_tready held at 1, the output is 1 sample/cycle for the whole block.
  - Back-to-back full banks stream with at most 2 idle cycles between blocks.
  - Input sustains 1 sample/cycle until both banks are FULL. s_axis_tready then drops to 0 in the cycle after the second bank fills.
- bank_full, block_count and err_tlast are registered and update 1 cycle after their causing handshake.

## Test plan
- ROWS=4, COLS=8, mode 0, input 0..31 with tlast on 31, tready=1 → output 0,8,16,24,1,9,…,7,15,23,31; tlast only on 31; block_count=1; err_tlast=0.
- Same block with mode 1 → output 0,4,8,…,28,1,5,…,31; tlast on the last sample.
- Send 3 consecutive blocks with m_axis_tready=0 → s_axis_tready goes low after 64 samples and bank_full=2'b11. Then release tready → 96 samples are emitted in correct order, block_count=3.
- Random tready (50%) on a 2-block stream → output matches the reference permutation; data and tlast are stable while stalled; no drop and no duplicate.
- tlast at k=10 → err_tlast=1 one cycle later; the block is still emitted as 32 samples.
- Assert ARESETN low at k=17 of a block, and separately at n=5 of the output → all outputs return to reset values. The next full block interleaves correctly from index 0.
